keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Controller that owns the 4x4 keypad matrix: it schedules row strobes, samples the column lines, debounces press and release, decodes the row/column hit to a hex key code, and queues key events in a small FIFO. Downstream logic (digit display, user logic) drains the FIFO through a valid/ready handshake. It sits between the synchronized keypad column inputs and the display datapath, and replaces free-running row scanning with one sequenced, debounced event source.

## Interface
Parameters:
- SCAN_CYCLES, 16: cycles each row is driven before its columns are sampled (≥2).
- DEBOUNCE_CYCLES, 40: consecutive stable cycles required to accept a press or a release (≥1).
- FIFO_DEPTH, 4: key event queue depth (power of two, ≥2).
- REPEAT_CYCLES, 200: auto-repeat period. Used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  in  1: single clock.
- reset  in  1: synchronous, active-high.
- cols  in  4: column lines, active-high, already synchronized.
- rows  out  4: one-hot row drive.
- key_valid  out  1: FIFO non-empty.
- key_code  out  4: hex code at FIFO head; 0 when empty.
- key_ready  in  1: consumer accepts head when key_valid is high.
- overflow  out  1: one-cycle pulse when a key is dropped because the FIFO is full.

## Operation
Reset values:
- rows = 4'b0001, key_valid = 0, key_code = 0, overflow = 0.
- State SCAN, row index 0, all counters 0, FIFO empty.

State machine (states SCAN, DEBOUNCE, HELD):
- SCAN: drive the current row and count to SCAN_CYCLES-1.
  - At terminal count, if cols == 0: advance the row (3 wraps to 0) and clear the counter.
  - At terminal count, if cols != 0: latch the column pattern and enter DEBOUNCE on the same row.
- DEBOUNCE: the row stays driven.
  - Each cycle, if cols == latched pattern, increment the counter; otherwise return to SCAN on the next row.
  - When the counter reaches DEBOUNCE_CYCLES-1: push the key and enter HELD.
- HELD: the row stays driven.
  - Count consecutive cycles with cols == 0; any nonzero cols clears the count.
  - After DEBOUNCE_CYCLES zero cycles, return to SCAN on the next row.
  - No push occurs in HELD unless KEYPAD_REPEAT_EN is defined.

Key decode:
- If several columns are high, the lowest column index wins.
- Map: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D (E = '*', F = '#').

FIFO:
- Push happens at DEBOUNCE terminal count.
- Pop happens on key_valid && key_ready.
- Full with push and no pop: the key is dropped and overflow pulses.
- Full with simultaneous push and pop: both take effect, no overflow.
- Empty with simultaneous push and pop: the pop is ignored (key_valid was 0) and the push is accepted.

Counters are sized $clog2(max parameter)+1 bits and never wrap mid-count.

Reset mid-operation: reset in any state returns to the reset values on the next edge. The FIFO is flushed and any in-flight debounce is abandoned.

## Timing
- A row is driven for exactly SCAN_CYCLES cycles per scan slot. An idle full sweep takes 4*SCAN_CYCLES cycles.
- cols is sampled on the edge ending the slot's last cycle.
- Push occurs DEBOUNCE_CYCLES cycles after that sample.
- key_valid and key_code update one cycle after the push edge (registered FIFO outputs).
- The head changes the cycle after a pop.
- overflow is high for exactly one cycle, aligned with the rejected push edge.
- Worst-case press-to-valid latency from stable cols: 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 1 cycles.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter runs while cols stays equal to the latched pattern.
  - Every REPEAT_CYCLES cycles it pushes the same key code again; overflow rules apply.
  - Release or a pattern change resets the repeat counter.
- KEYPAD_REPEAT_EN undefined: exactly one push per accepted press, and the repeat counter logic is absent.

## Structure
- Shared package keypad_pkg holds:
  - typedef enum ctrl_state_t {SCAN, DEBOUNCE, HELD};
  - the 16-entry row/column-to-code map constant;
  - a key_code_t 4-bit typedef.
- One sub-module, key_fifo:
  - parameterized by depth;
  - ports push, push_data, pop, data, valid, full.
- The FSM, counters and decode live in the top module.

## Test plan
Bench parameters: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, FIFO_DEPTH=4.
- Reset release, cols=0 → rows cycles 0001, 0010, 0100, 1000, 0001, each for 4 cycles; key_valid stays 0.
- cols=0100 held only while rows=0010 → one event with key_code=6; key_valid rises 9 cycles after the sample; key_ready=1 pops it next cycle.
- Bounce: cols=0001 on row0 drops to 0 after 3 debounce cycles → no push; scan resumes on row1.
- Five presses (1, 5, 9, 0, A) with key_ready=0 → first four queued in order; overflow pulses once on the fifth; draining yields 1, 5, 9, 0.
- FIFO full with key_ready=1 on the same edge as a push → no overflow; occupancy stays 4.
- With KEYPAD_REPEAT_EN, REPEAT_CYCLES=20, key 'D' held 50 cycles after acceptance → three 'D' events total. Without the macro → exactly one.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key map and helpers for the keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} ctrl_state_t;

  typedef logic [3:0] key_code_t;

  // Indexed by {row, column}; '*' is E and '#' is F.
  localparam key_code_t KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Several columns high at once: the lowest index wins.
  function automatic logic [1:0] lowest_col(input logic [3:0] pat);
    logic [1:0] col;
    col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pat[i]) col = i[1:0];
    end
    return col;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small key-event queue; outputs are registered and show pops at once but pushes one cycle late.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  key_code_t push_data,
  input  logic      pop,
  output key_code_t data,
  output logic      valid,
  output logic      full
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  key_code_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  key_code_t       data_q, data_d;
  logic            pop_ok, wr_en;

  assign full   = (cnt_q == CNTW'(DEPTH));
  assign pop_ok = pop && valid_q;
  assign wr_en  = push && (!full || pop_ok);

  // Output view excludes this edge's push so a new key surfaces one cycle after it lands.
  always_comb begin
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + CNTW'(wr_en) - CNTW'(pop_ok);
    valid_d = (cnt_q - CNTW'(pop_ok)) != '0;
    data_d  = valid_d ? mem_q[rd_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, press/release debounce, hex decode and a key-event FIFO.
// Define KEYPAD_REPEAT_EN to re-queue a held key every REPEAT_CYCLES cycles.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 40,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_CYCLES   = 200
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic      key_valid,
  output key_code_t key_code,
  input  logic      key_ready,
  output logic      overflow
);

  localparam int CW = $clog2(max3(SCAN_CYCLES, DEBOUNCE_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  ctrl_state_t   state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic          overflow_q, overflow_d;
  logic          deb_push, rep_push, push_any, pop, fifo_full;
  key_code_t     decoded;

  assign decoded = KEY_MAP[{row_q, lowest_col(pat_q)}];

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    deb_push = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (cols == 4'b0000) begin
            row_d = row_q + 2'd1;
          end else begin
            pat_d   = cols;
            state_d = DEBOUNCE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (cols != pat_q) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          deb_push = 1'b1;
          state_d  = HELD;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        // Release needs an unbroken run of quiet cycles; any bounce restarts it.
        if (cols != 4'b0000) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rep_q, rep_d;

  always_comb begin
    rep_d    = '0;
    rep_push = 1'b0;
    if (state_q == HELD && cols == pat_q) begin
      if (rep_q == REP_LAST) begin
        rep_push = 1'b1;
      end else begin
        rep_d = rep_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`else
  assign rep_push = 1'b0;
`endif

  assign push_any   = deb_push | rep_push;
  assign pop        = key_valid & key_ready;
  assign overflow_d = push_any & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      cnt_q      <= '0;
      pat_q      <= 4'b0000;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      overflow_q <= overflow_d;
    end
  end

  key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_any),
    .push_data(decoded),
    .pop      (pop),
    .data     (key_code),
    .valid    (key_valid),
    .full     (fifo_full)
  );

  assign rows     = 4'b0001 << row_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a matrix keypad model and an expected-key scoreboard.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

  localparam int SCAN  = 4;
  localparam int DEB   = 8;
  localparam int DEPTH = 4;
  localparam int REP   = 20;
`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_EVENTS = 3;
`else
  localparam int HOLD_EVENTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_ready = 1'b0;
  logic [3:0] cols, rows, key_code;
  logic       key_valid, overflow;

  logic       key_down = 1'b0;
  logic [1:0] kp_row = 2'd0;
  logic [3:0] kp_cols = 4'b0000;

  int n_assert = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;
  int exp_ovf  = 0;
  int occ      = 0;
  logic [3:0] exp_q [$];

  // The pressed key connects its row strobe to its column lines.
  assign cols = (key_down && rows[kp_row]) ? kp_cols : 4'b0000;

  always #5 clk = ~clk;

  always @(negedge clk) if (overflow) ovf_cnt++;

  keypad_scan_ctrl #(
    .SCAN_CYCLES    (SCAN),
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .rows     (rows),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .overflow (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Returns just after the edge that starts a fresh scan slot on row r.
  task automatic wait_slot_start(input int r, input string tag);
    logic [3:0] prev;
    logic [3:0] want;
    int         n;
    logic       found;
    want  = 4'b0001 << r;
    found = 1'b0;
    n     = 0;
    while (!found && n < 64) begin
      prev = rows;
      tick();
      n++;
      found = (rows == want) && (prev != want);
    end
    check(tag, found, 1);
  endtask

  task automatic press_key(input int r, input logic [3:0] c, input logic [3:0] code,
                           input logic ready_at_push, input int extra, input string tag);
    wait_slot_start((r + 3) % 4, {tag, "_pre"});
    kp_row   = r[1:0];
    kp_cols  = c;
    key_down = 1'b1;
    wait_slot_start(r, {tag, "_slot"});
    if (ready_at_push) begin
      repeat (SCAN + DEB - 1) tick();
      if (exp_q.size() > 0) check({tag, "_head"}, key_code, exp_q.pop_front());
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      exp_q.push_back(code);
    end else begin
      repeat (SCAN + DEB) tick();
      if (occ < DEPTH) begin
        exp_q.push_back(code);
        occ++;
      end else begin
        exp_ovf++;
      end
    end
    repeat (extra) tick();
    key_down = 1'b0;
    wait_slot_start((r + 1) % 4, {tag, "_rel"});
  endtask

  task automatic drain_one(input string tag);
    int n = 0;
    while (!key_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, key_valid, 1);
    if (exp_q.size() > 0) check({tag, "_code"}, key_code, exp_q.pop_front());
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    if (occ > 0) occ--;
    if (exp_q.size() > 0) check({tag, "_next"}, key_code, exp_q[0]);
  endtask

  initial begin
    int lat;
    int seen;

    // Reset state and an idle sweep.
    repeat (3) tick();
    check("rst_rows", rows, 4'b0001);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle_rows_%0d", i), rows, 4'b0001 << ((i / SCAN) % 4));
      tick();
    end
    check("idle_valid", key_valid, 0);

    // Single press of '6', latency and pop.
    wait_slot_start(0, "s2_pre");
    kp_row   = 2'd1;
    kp_cols  = 4'b0100;
    key_down = 1'b1;
    exp_q.push_back(4'h6);
    occ++;
    wait_slot_start(1, "s2_slot");
    lat = 0;
    while (!key_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("s2_latency", lat, SCAN + DEB + 1);
    check("s2_row_held", rows, 4'b0010);
    drain_one("s2");
    check("s2_empty_valid", key_valid, 0);
    check("s2_empty_code", key_code, 0);
    key_down = 1'b0;
    wait_slot_start(2, "s2_rel");

    // Bounce on row0 abandoned after 3 debounce cycles.
    wait_slot_start(3, "s3_pre");
    kp_row   = 2'd0;
    kp_cols  = 4'b0001;
    key_down = 1'b1;
    wait_slot_start(0, "s3_slot");
    repeat (SCAN + 3) tick();
    check("s3_row_held", rows, 4'b0001);
    key_down = 1'b0;
    tick();
    check("s3_next_row", rows, 4'b0010);
    repeat (SCAN - 1) tick();
    check("s3_row1_slot", rows, 4'b0010);
    tick();
    check("s3_row2", rows, 4'b0100);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (key_valid) seen++;
      tick();
    end
    check("s3_no_push", seen, 0);

    // Five presses with no consumer: fifth overflows.
    press_key(0, 4'b0001, 4'h1, 1'b0, 0, "s4_k1");
    press_key(1, 4'b0010, 4'h5, 1'b0, 0, "s4_k5");
    press_key(2, 4'b0100, 4'h9, 1'b0, 0, "s4_k9");
    press_key(3, 4'b0010, 4'h0, 1'b0, 0, "s4_k0");
    press_key(0, 4'b1000, 4'hA, 1'b0, 0, "s4_kA");
    check("s4_ovf_cycles", ovf_cnt, exp_ovf);
    for (int i = 0; i < 4; i++) drain_one($sformatf("s4_drain%0d", i));
    check("s4_empty", key_valid, 0);

    // Full FIFO with pop on the push edge: no overflow, occupancy stays full.
    press_key(0, 4'b0001, 4'h1, 1'b0, 0, "s5_k1");
    press_key(1, 4'b0010, 4'h5, 1'b0, 0, "s5_k5");
    press_key(2, 4'b0100, 4'h9, 1'b0, 0, "s5_k9");
    press_key(3, 4'b0010, 4'h0, 1'b0, 0, "s5_k0");
    press_key(0, 4'b1000, 4'hA, 1'b1, 0, "s5_kA");
    check("s5_ovf_cycles", ovf_cnt, exp_ovf);
    for (int i = 0; i < 4; i++) drain_one($sformatf("s5_drain%0d", i));
    check("s5_empty", key_valid, 0);

    // Key 'D' held 50 cycles after acceptance.
    press_key(3, 4'b1000, 4'hD, 1'b0, 50, "s6_kD");
    for (int i = 1; i < HOLD_EVENTS; i++) begin
      exp_q.push_back(4'hD);
      occ++;
    end
    for (int i = 0; i < HOLD_EVENTS; i++) drain_one($sformatf("s6_drain%0d", i));
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (key_valid) seen++;
      tick();
    end
    check("s6_no_extra", seen, 0);
    check("s6_ovf_cycles", ovf_cnt, exp_ovf);

    // Reset mid-debounce with a queued key flushes everything.
    press_key(0, 4'b0001, 4'h1, 1'b0, 0, "s7_k1");
    wait_slot_start(0, "s7_pre");
    kp_row   = 2'd1;
    kp_cols  = 4'b0010;
    key_down = 1'b1;
    wait_slot_start(1, "s7_slot");
    repeat (SCAN + 2) tick();
    check("s7_valid_before", key_valid, 1);
    reset = 1'b1;
    tick();
    key_down = 1'b0;
    reset    = 1'b0;
    exp_q.delete();
    occ = 0;
    check("s7_rst_rows", rows, 4'b0001);
    check("s7_rst_valid", key_valid, 0);
    check("s7_rst_code", key_code, 0);
    repeat (SCAN) tick();
    check("s7_rescan", rows, 4'b0010);
    check("s7_still_empty", key_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
